// File: rtl/xmit_parity_pkg.sv
// Shared types, parity-mode encodings and sizing helper for the transmit parity engine.
// Optional feature macro: XMIT_PARITY_STICKY_EN (adds mark/space parity modes).
package xmit_parity_pkg;

   typedef enum logic {IDLE, ACCUM} state_t;

`ifdef XMIT_PARITY_STICKY_EN
   localparam int unsigned PM_W = 2;
`else
   localparam int unsigned PM_W = 1;
`endif

   localparam logic [1:0] PM_EVEN  = 2'b00;
   localparam logic [1:0] PM_ODD   = 2'b01;
   localparam logic [1:0] PM_MARK  = 2'b10;
   localparam logic [1:0] PM_SPACE = 2'b11;

   function automatic int unsigned cnt_width(input int unsigned data_bits);
      return (data_bits > 1) ? $clog2(data_bits) : 1;
   endfunction

endpackage

// File: rtl/xmit_parity_lane.sv
// One serial lane: parity accumulator plus registered parity output.
// Optional feature macro: XMIT_PARITY_STICKY_EN (mark/space override at the output register).
module xmit_parity_lane (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_start,
   input  logic i_enable,
   input  logic i_seed,
   input  logic i_din,
   input  logic i_done,
`ifdef XMIT_PARITY_STICKY_EN
   input  logic i_force_en,
   input  logic i_force_val,
`endif
   output logic o_parity
);

   logic r_acc;
   logic r_parity;
   logic w_acc_base;
   logic w_acc_next;
   logic w_par_next;

   // Start reseeds before this cycle's bit is folded in, so bit 0 can share the Start cycle.
   assign w_acc_base = i_start ? i_seed : r_acc;
   assign w_acc_next = w_acc_base ^ (i_enable & i_din);

`ifdef XMIT_PARITY_STICKY_EN
   assign w_par_next = i_force_en ? i_force_val : w_acc_next;
`else
   assign w_par_next = w_acc_next;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc    <= 1'b0;
         r_parity <= 1'b0;
      end else begin
         if (i_load) r_acc <= w_acc_next;
         if (i_done) r_parity <= w_par_next;
      end
   end

   assign o_parity = r_parity;

endmodule

// File: rtl/xmit_parity_engine.sv
// Multi-lane frame-aware transmit parity generator: FSM, bit counter, mode latch, valid strobe.
// Optional feature macro: XMIT_PARITY_STICKY_EN (ParMode widens to 2 bits for mark/space).
module xmit_parity_engine
   import xmit_parity_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned LANES     = 1
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_start,
   input  logic                                 i_enable,
   input  logic [LANES-1:0]                     i_din,
   input  logic [PM_W-1:0]                      i_par_mode,
   output logic [LANES-1:0]                     o_parity,
   output logic                                 o_parity_valid,
   output logic                                 o_busy,
   output logic [cnt_width(DATA_BITS)-1:0]      o_bit_count
);

   localparam int unsigned     CNT_W = cnt_width(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [PM_W-1:0]   r_mode;
   logic [PM_W-1:0]   w_mode;
   logic              r_valid;
   logic              w_done;
   logic              w_load;
   logic              w_seed;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_mode  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_valid <= w_done;
         if (i_start) r_mode <= i_par_mode;
      end
   end

   // Start wins over an in-flight final bit: the old frame is dropped, never completed.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_done       = 1'b0;
      if (i_start) begin
         w_state_next = ACCUM;
         w_cnt_next   = '0;
         if (i_enable) begin
            if (DATA_BITS == 1) begin
               w_done       = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = CNT_W'(1);
            end
         end
      end else if (r_state == ACCUM && i_enable) begin
         if (r_cnt == LAST) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

   // The mode in force this cycle: freshly sampled on Start, otherwise the latched one.
   assign w_mode = i_start ? i_par_mode : r_mode;
   assign w_seed = w_mode[0];
   assign w_load = i_start | ((r_state == ACCUM) & i_enable);

`ifdef XMIT_PARITY_STICKY_EN
   logic w_force_en;
   logic w_force_val;
   assign w_force_en  = (w_mode == PM_MARK) || (w_mode == PM_SPACE);
   assign w_force_val = (w_mode == PM_MARK);
`endif

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      xmit_parity_lane u_lane (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_load      (w_load),
         .i_start     (i_start),
         .i_enable    (i_enable),
         .i_seed      (w_seed),
         .i_din       (i_din[g]),
         .i_done      (w_done),
`ifdef XMIT_PARITY_STICKY_EN
         .i_force_en  (w_force_en),
         .i_force_val (w_force_val),
`endif
         .o_parity    (o_parity[g])
      );
   end

   assign o_parity_valid = r_valid;
   assign o_busy         = (r_state == ACCUM);
   assign o_bit_count    = r_cnt;

endmodule

// File: tb/tb_xmit_parity_engine.sv
// Self-checking bench for xmit_parity_engine: directed frames plus random traffic vs. a frame model.
// Honours XMIT_PARITY_STICKY_EN when defined (adds mark/space checks).
module tb_xmit_parity_engine;
   import xmit_parity_pkg::*;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned LANES     = 2;
   localparam int unsigned CNT_W     = cnt_width(DATA_BITS);

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               enable = 1'b0;
   logic [LANES-1:0]   din = '0;
   logic [PM_W-1:0]    par_mode = '0;
   logic [LANES-1:0]   parity;
   logic               parity_valid;
   logic               busy;
   logic [CNT_W-1:0]   bit_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_pulses = 0;
   int last_pulse = 0;
   int prev_pulse = 0;

   // Reference model: a frame is a list of collected lane vectors; parity is computed on completion.
   logic [LANES-1:0] frame[$];
   bit               m_active = 0;
   int               m_mode   = 0;
   logic [LANES-1:0] exp_parity = '0;
   logic             exp_valid  = 1'b0;

   xmit_parity_engine #(
      .DATA_BITS (DATA_BITS),
      .LANES     (LANES)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_enable       (enable),
      .i_din          (din),
      .i_par_mode     (par_mode),
      .o_parity       (parity),
      .o_parity_valid (parity_valid),
      .o_busy         (busy),
      .o_bit_count    (bit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      frame.delete();
      m_active   = 0;
      m_mode     = 0;
      exp_parity = '0;
      exp_valid  = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic e, input logic [LANES-1:0] d,
                             input logic [PM_W-1:0] m);
      exp_valid = 1'b0;
      if (s) begin
         frame.delete();
         m_active = 1;
         m_mode   = int'(m);
         if (e) frame.push_back(d);
      end else if (m_active && e) begin
         frame.push_back(d);
      end
      if (m_active && frame.size() == DATA_BITS) begin
         for (int l = 0; l < LANES; l++) begin
            logic p;
            p = (m_mode == 1);
            foreach (frame[b]) p = p ^ frame[b][l];
            if (m_mode == 2) p = 1'b1;
            if (m_mode == 3) p = 1'b0;
            exp_parity[l] = p;
         end
         exp_valid = 1'b1;
         m_active  = 0;
         frame.delete();
      end
   endtask

   task automatic step(input logic s, input logic e, input logic [LANES-1:0] d,
                       input logic [PM_W-1:0] m);
      start    = s;
      enable   = e;
      din      = d;
      par_mode = m;
      @(posedge clk);
      model_edge(s, e, d, m);
      #1;
      cyc++;
      check("parity", 32'(parity), 32'(exp_parity));
      check("valid", 32'(parity_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(m_active));
      check("bit_count", 32'(bit_count), 32'(frame.size()));
      if (parity_valid) begin
         n_pulses++;
         prev_pulse = last_pulse;
         last_pulse = cyc;
      end
   endtask

   // Bit i of each lane word is sent in frame position i; gap idle cycles between bits.
   task automatic send_frame(input logic [7:0] l0, input logic [7:0] l1,
                             input logic [PM_W-1:0] m, input int gap);
      step(1'b1, 1'b1, {l1[0], l0[0]}, m);
      for (int i = 1; i < DATA_BITS; i++) begin
         for (int g = 0; g < gap; g++) step(1'b0, 1'b0, LANES'($urandom), PM_W'($urandom));
         step(1'b0, 1'b1, {l1[i], l0[i]}, PM_W'($urandom));
      end
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_parity", 32'(parity), 32'd0);
      check("rst_valid", 32'(parity_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(bit_count), 32'd0);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int c0;
      int p0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("por_busy", 32'(busy), 32'd0);
      check("por_valid", 32'(parity_valid), 32'd0);
      rst_n = 1'b1;

      // Reset mid-frame, then Enable without Start must be ignored.
      step(1'b1, 1'b1, 2'b11, PM_W'(0));
      repeat (4) step(1'b0, 1'b1, 2'b01, PM_W'(0));
      check("t1_count5", 32'(bit_count), 32'd5);
      async_reset();
      step(1'b0, 1'b1, 2'b11, PM_W'(0));
      step(1'b0, 1'b1, 2'b10, PM_W'(1));

      // Even then odd, Enable every cycle.
      c0 = cyc;
      p0 = n_pulses;
      send_frame(8'hB2, 8'hFF, PM_W'(0), 0);
      check("t2_even_par", 32'(parity), 32'h0);
      check("t2_latency", 32'(last_pulse - c0), 32'd8);
      step(1'b0, 1'b0, 2'b00, PM_W'(0));
      send_frame(8'hB2, 8'hFF, PM_W'(1), 0);
      check("t2_odd_par", 32'(parity), 32'h3);
      check("t2_pulses", 32'(n_pulses - p0), 32'd2);

      // Enable gaps give identical results.
      send_frame(8'hB2, 8'hFF, PM_W'(0), 2);
      check("t3_gap_even", 32'(parity), 32'h0);
      send_frame(8'hB2, 8'hFF, PM_W'(1), 2);
      check("t3_gap_odd", 32'(parity), 32'h3);

      // Abort at BitCount=4, then a full new frame.
      p0 = n_pulses;
      step(1'b1, 1'b1, 2'b11, PM_W'(1));
      repeat (3) step(1'b0, 1'b1, 2'b01, PM_W'(1));
      check("t4_count4", 32'(bit_count), 32'd4);
      send_frame(8'h01, 8'h00, PM_W'(0), 0);
      check("t4_pulses", 32'(n_pulses - p0), 32'd1);
      check("t4_par0", 32'(parity[0]), 32'd1);

      // Back-to-back frames with a one-cycle bubble.
      step(1'b0, 1'b0, 2'b00, PM_W'(0));
      send_frame(8'h5A, 8'h3C, PM_W'(0), 0);
      step(1'b0, 1'b0, 2'b00, PM_W'(0));
      check("t5_bubble_busy", 32'(busy), 32'd0);
      send_frame(8'hC3, 8'h81, PM_W'(1), 0);
      check("t5_spacing", 32'(last_pulse - prev_pulse), 32'd9);

`ifdef XMIT_PARITY_STICKY_EN
      c0 = cyc;
      send_frame(8'h00, 8'h00, 2'b10, 0);
      check("t6_mark", 32'(parity), 32'h3);
      check("t6_mark_lat", 32'(last_pulse - c0), 32'd8);
      c0 = cyc;
      send_frame(8'hFF, 8'hFF, 2'b11, 0);
      check("t6_space", 32'(parity), 32'h0);
      check("t6_space_lat", 32'(last_pulse - c0), 32'd8);
`endif

      // Random traffic with occasional mid-run resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) async_reset();
         step($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
              LANES'($urandom), PM_W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
